quad_enc_multi: RTL
===================

Name: quad_enc_multi

Overview:
- Parametrised successor to the basic quadrature decoder.
- Adds the following to the quadrature-to-position function:
  - configurable count width
  - per-input glitch filter
  - Z-index latch/reset
  - illegal-transition fault detection
  - windowed velocity measurement
- Sits between encoder pins and the motion-control register file; count, index and velocity outputs are read by the CPU/SPI side.

Parameters:
- COUNT_W, 32, width of signed position count
- FILTER_LEN, 3, consecutive identical synchronised samples required before a filtered input changes (1..15)
- VEL_W, 16, width of signed velocity output
- VEL_WINDOW, 1000, clk cycles per velocity measurement window (>=2)

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- a, b, z  in  1 each  raw asynchronous encoder channels
- multiplier  in  8  unsigned step magnitude (0..255)
- invert_dir  in  1  swap forward/reverse sign
- count_load  in  1  load load_value into count
- load_value  in  COUNT_W  value for count_load
- index_latch_en  in  1  enable latching count on Z rise
- index_reset_en  in  1  enable zeroing count on Z rise
- index_ack  in  1  clears index_valid
- fault_clear  in  1  clears fault
- count  out  COUNT_W  signed position
- index_count  out  COUNT_W  count captured at last Z rise
- index_valid  out  1  index_count fresh, sticky until ack
- fault  out  1  sticky illegal-transition flag
- velocity  out  VEL_W  signed counts per window, saturated
- vel_valid  out  1  one-cycle pulse when velocity updates

Behaviour:
- Reset (resetn low at posedge): all outputs 0, synchronisers/filters/state cleared, window counter 0. Filtered a/b/z and prev state reset to 0.
- Input conditioning:
  - Each of a, b, z passes through a 2-FF synchroniser, then a filter.
  - Filtered value takes the synchronised level only after FILTER_LEN consecutive equal samples.
  - A shorter pulse never reaches the filtered output.
- Decode (on filtered {a,b} vs previous filtered {a,b}):
  - Forward sequence (a,b): 00→10→11→01→00. Reverse is the opposite order.
  - Forward applies +multiplier, reverse applies −multiplier. invert_dir swaps the signs.
  - multiplier is zero-extended to COUNT_W before negation, so 255 gives −255.
  - Both bits changing in one step: no count change, fault←1.
  - No change: nothing happens.
- Latency: count reflects a clean edge held on a or b exactly FILTER_LEN+3 clk edges after the edge that first samples it.
- Arithmetic: count wraps modulo 2^COUNT_W (0x7FFFFFFF +1 → 0x80000000).
- Count-update priority per cycle:
  1. reset
  2. count_load (step discarded)
  3. Z rise with index_reset_en (count←0, step discarded)
  4. step
- Index, on a filtered-Z rising edge:
  - With index_latch_en: index_count ← count as it stands before this cycle's update; index_valid←1.
  - index_ack clears index_valid. A simultaneous new latch wins (valid stays 1, new value).
- Fault:
  - Set on an illegal transition; held until fault_clear.
  - Simultaneous set and clear: set wins.
- Velocity:
  - A window counter runs 0..VEL_WINDOW-1.
  - A signed accumulator sums applied step increments (load, index reset and illegal steps contribute 0).
  - On the final window cycle: velocity ← accumulator + current increment, saturated to ±(2^(VEL_W-1)−1) / −2^(VEL_W-1); vel_valid=1 for that one cycle; accumulator←0.
  - Accumulator is internally COUNT_W wide.
- Reset mid-operation clears everything, including partial windows and pending filter counts.

Test Plan:
1. FILTER_LEN=3, multiplier=4: drive 8 clean forward quadrature states, each held 10 cycles → count=32. Each update lands 6 clk after the input change. Reverse 8 states → count=0.
2. Glitch: 2-cycle pulse on a with FILTER_LEN=3 → count unchanged, fault=0. A 3-cycle pulse → two steps (+1, then −1), net 0.
3. Illegal: {a,b} 00→11 held → count unchanged, fault=1. fault_clear → 0. fault_clear asserted in the same cycle as a new illegal step → fault stays 1.
4. Index: count=100, index_latch_en=1, Z rise → index_count=100, index_valid=1. With index_reset_en=1 also set → count=0 next cycle. index_ack → valid=0.
5. Wrap and load: load 0x7FFFFFFF, one forward step with multiplier=1 → 0x80000000. multiplier=255 in reverse from 0 → −255 (0xFFFFFF01).
6. Velocity, VEL_WINDOW=100, VEL_W=8, multiplier=50: 4 forward steps in the window → velocity=127 (saturated) with a single vel_valid pulse. 1 step in the next window → velocity=50.

Source files
------------

// File: rtl/quad_enc_multi.sv
// quad_enc_multi: quadrature decoder with input synchronisers, glitch filters,
// scalable step size, Z-index latch/zero, illegal-transition fault and
// windowed velocity measurement.
module quad_enc_multi #(
    parameter int COUNT_W    = 32,
    parameter int FILTER_LEN = 3,
    parameter int VEL_W      = 16,
    parameter int VEL_WINDOW = 1000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               a,
    input  logic               b,
    input  logic               z,
    input  logic [7:0]         multiplier,
    input  logic               invert_dir,
    input  logic               count_load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               index_latch_en,
    input  logic               index_reset_en,
    input  logic               index_ack,
    input  logic               fault_clear,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] index_count,
    output logic               index_valid,
    output logic               fault,
    output logic [VEL_W-1:0]   velocity,
    output logic               vel_valid
);

    localparam int WIN_W = $clog2(VEL_WINDOW);
    localparam logic [3:0]       FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(VEL_WINDOW - 1);
    // Saturation limits expressed at accumulator width
    localparam logic signed [COUNT_W-1:0] VEL_MAX = COUNT_W'((2 ** (VEL_W - 1)) - 1);
    localparam logic signed [COUNT_W-1:0] VEL_MIN = ~VEL_MAX;

    // Channel bit order in the 3-bit vectors: [0]=a, [1]=b, [2]=z
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       filt_q, filt_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0][3:0]  fcnt_q, fcnt_d;

    logic signed [COUNT_W-1:0] count_q, count_d;
    logic signed [COUNT_W-1:0] index_count_q, index_count_d;
    logic signed [COUNT_W-1:0] acc_q, acc_d;
    logic                      index_valid_q, index_valid_d;
    logic                      fault_q, fault_d;
    logic [VEL_W-1:0]          velocity_q, velocity_d;
    logic                      vel_valid_q, vel_valid_d;
    logic [WIN_W-1:0]          win_q, win_d;

    logic [1:0]                cur_pos, prev_pos, delta;
    logic                      is_fwd, is_rev, illegal, z_rise, idx_zero, win_last;
    logic signed [COUNT_W-1:0] mult_ext, step, applied, vel_sum;
    logic [VEL_W-1:0]          vel_sat;

    // Synchronise raw pins and filter: a channel only follows its synchronised
    // level after FILTER_LEN consecutive samples that differ from the current output
    always_comb begin
        sync1_d = {z, b, a};
        sync2_d = sync1_q;
        filt_d  = filt_q;
        fcnt_d  = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
        prev_d = filt_q;
    end

    // Decode: map gray states 00,10,11,01 to positions 0..3 so the position
    // difference tells forward (+1), reverse (-1) or illegal (2)
    always_comb begin
        cur_pos  = {filt_q[1], filt_q[0] ^ filt_q[1]};
        prev_pos = {prev_q[1], prev_q[0] ^ prev_q[1]};
        delta    = cur_pos - prev_pos;
        is_fwd   = (delta == 2'b01);
        is_rev   = (delta == 2'b11);
        illegal  = (delta == 2'b10);
        mult_ext = {{(COUNT_W-8){1'b0}}, multiplier};
        step     = '0;
        if (is_fwd || is_rev) begin
            step = (is_fwd ^ invert_dir) ? mult_ext : -mult_ext;
        end
        z_rise   = filt_q[2] & ~prev_q[2];
        idx_zero = z_rise & index_reset_en;
        // Only steps that actually move the count feed the velocity window
        applied  = (count_load || idx_zero) ? '0 : step;
    end

    // Next-state for count, index, fault and velocity window
    always_comb begin
        if (count_load) begin
            count_d = load_value;
        end else if (idx_zero) begin
            count_d = '0;
        end else begin
            count_d = count_q + step;
        end

        index_count_d = index_count_q;
        index_valid_d = index_valid_q;
        if (z_rise && index_latch_en) begin
            index_count_d = count_q;
            index_valid_d = 1'b1;
        end else if (index_ack) begin
            index_valid_d = 1'b0;
        end

        fault_d = fault_q;
        if (illegal) begin
            fault_d = 1'b1;
        end else if (fault_clear) begin
            fault_d = 1'b0;
        end

        win_last = (win_q == WIN_LAST);
        vel_sum  = acc_q + applied;
        if (vel_sum > VEL_MAX) begin
            vel_sat = VEL_MAX[VEL_W-1:0];
        end else if (vel_sum < VEL_MIN) begin
            vel_sat = VEL_MIN[VEL_W-1:0];
        end else begin
            vel_sat = vel_sum[VEL_W-1:0];
        end

        win_d       = win_last ? '0 : win_q + 1'b1;
        acc_d       = win_last ? '0 : vel_sum;
        velocity_d  = win_last ? vel_sat : velocity_q;
        vel_valid_d = win_last;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            filt_q        <= '0;
            prev_q        <= '0;
            fcnt_q        <= '0;
            count_q       <= '0;
            index_count_q <= '0;
            index_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            acc_q         <= '0;
            win_q         <= '0;
            velocity_q    <= '0;
            vel_valid_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            filt_q        <= filt_d;
            prev_q        <= prev_d;
            fcnt_q        <= fcnt_d;
            count_q       <= count_d;
            index_count_q <= index_count_d;
            index_valid_q <= index_valid_d;
            fault_q       <= fault_d;
            acc_q         <= acc_d;
            win_q         <= win_d;
            velocity_q    <= velocity_d;
            vel_valid_q   <= vel_valid_d;
        end
    end

    assign count       = count_q;
    assign index_count = index_count_q;
    assign index_valid = index_valid_q;
    assign fault       = fault_q;
    assign velocity    = velocity_q;
    assign vel_valid   = vel_valid_q;

endmodule
